// File: rtl/cfg_readback_tx.sv
// cfg_readback_tx: dumps the channel-parameter table over a UART 8N1 line as
// one frame: header byte, N_BYTES table bytes starting at address 0, then an
// 8-bit additive checksum of the table bytes.
module cfg_readback_tx #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned N_BYTES = 112,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic       clk_TX,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] r_addr,
  input  logic [7:0] r_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned   BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [7:0]    ADDR_LAST = 8'(N_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR_BIT,
    FETCH,
    DATA_BIT,
    CSUM_BIT,
    FINISH
  } state_t;

  state_t        state, state_d;
  logic [BW-1:0] baud_cnt, baud_d;
  logic [3:0]    bit_cnt, bit_d;
  logic [9:0]    sreg, sreg_d;
  logic [7:0]    acc, acc_d;
  logic [7:0]    addr_d;
  logic          last_byte, last_d;
  logic          busy_d, done_d;
  logic          bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // The line is the LSB of the shift register, so tx is a flop output and
  // idles high because the register rests at all ones.
  assign tx = sreg[0];

  // State, counters, shift register, accumulator and outputs.
  always_ff @(posedge clk_TX or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      sreg      <= '1;
      acc       <= '0;
      r_addr    <= '0;
      last_byte <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      baud_cnt  <= baud_d;
      bit_cnt   <= bit_d;
      sreg      <= sreg_d;
      acc       <= acc_d;
      r_addr    <= addr_d;
      last_byte <= last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state logic. FETCH is the stop bit of a byte that is followed by a
  // table byte; that byte is latched at the end of FETCH. The address for the
  // following byte is advanced at that same latch, a full byte time ahead.
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_cnt;
    sreg_d  = sreg;
    acc_d   = acc;
    addr_d  = r_addr;
    last_d  = last_byte;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = HDR_BIT;
          addr_d  = '0;
          acc_d   = '0;
          last_d  = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
          sreg_d  = {1'b1, HDR, 1'b0};
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        if (!bit_end) begin
          baud_d = baud_cnt + BW'(1);
        end else begin
          baud_d = '0;
          if (bit_cnt != 4'd9) begin
            bit_d  = bit_cnt + 4'd1;
            sreg_d = {1'b1, sreg[9:1]};
            if (bit_cnt == 4'd8 &&
                (state == HDR_BIT || (state == DATA_BIT && !last_byte))) begin
              state_d = FETCH;
            end
          end else begin
            bit_d = '0;
            if (state == FETCH) begin
              sreg_d  = {1'b1, r_data, 1'b0};
              acc_d   = acc + r_data;
              state_d = DATA_BIT;
              if (r_addr == ADDR_LAST) begin
                last_d = 1'b1;
              end else begin
                addr_d = r_addr + 8'd1;
              end
            end else if (state == DATA_BIT) begin
              sreg_d  = {1'b1, acc, 1'b0};
              state_d = CSUM_BIT;
            end else begin
              sreg_d  = '1;
              state_d = FINISH;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
    endcase
  end

endmodule
